imm_ext_pipe: RTL and testbench

//  Pipelined, parametrised immediate/offset extender for the LC-3 datapath and later wider cores.

---
 rtl/lc3_pkg.sv | 18 +
 rtl/sext_core.sv | 35 +++
 rtl/imm_ext_pipe.sv | 99 +++++++++
 tb/tb_imm_ext_pipe.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// Shared LC-3 decode constants: immediate/offset field widths and extension modes.
// Also provides the default geometry used by the immediate extender.
package lc3_pkg;

  localparam int LC3_DATA_W    = 16;
  localparam int LC3_IN_W      = 12;
  localparam int LC3_WID_W     = 4;
  localparam int LC3_ERR_CNT_W = 8;

  localparam logic [LC3_WID_W-1:0] W_IMM5    = 4'd5;
  localparam logic [LC3_WID_W-1:0] W_OFF6    = 4'd6;
  localparam logic [LC3_WID_W-1:0] W_PCOFF9  = 4'd9;
  localparam logic [LC3_WID_W-1:0] W_PCOFF11 = 4'd11;

  localparam logic EXT_ZERO = 1'b0;
  localparam logic EXT_SIGN = 1'b1;

endpackage

// File: rtl/sext_core.sv
// Combinational field extender: keeps the low 'width' bits of 'value' and fills the rest
// with zeros or the field's top bit. Illegal widths (0 or > IN_W) give zero and raise err.
module sext_core #(
  parameter int IN_W   = 12,
  parameter int DATA_W = 16,
  parameter int WID_W  = 4
) (
  input  logic [IN_W-1:0]   value,
  input  logic [WID_W-1:0]  width,
  input  logic              sext,
  output logic [DATA_W-1:0] result,
  output logic              err
);

  logic              legal;
  logic              sign_bit;
  logic [DATA_W-1:0] keep_mask;
  logic [DATA_W-1:0] value_ext;

  always_comb begin
    legal     = (width != '0) && (32'(width) <= IN_W);
    value_ext = DATA_W'(value);
    keep_mask = ~({DATA_W{1'b1}} << width);
    // The field's top bit; the shift amount is only meaningful when width is legal.
    sign_bit  = |(value & (IN_W'(1) << (width - WID_W'(1))));
    if (legal) begin
      result = (value_ext & keep_mask) | ((sext && sign_bit) ? ~keep_mask : '0);
      err    = 1'b0;
    end else begin
      result = '0;
      err    = 1'b1;
    end
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Two-stage valid/ready immediate extender: stage 1 holds the raw field, stage 2 the
// extended result. Also keeps a saturating count of illegal-width results delivered.
module imm_ext_pipe
  import lc3_pkg::*;
#(
  parameter int DATA_W    = LC3_DATA_W,
  parameter int IN_W      = LC3_IN_W,
  parameter int WID_W     = LC3_WID_W,
  parameter int ERR_CNT_W = LC3_ERR_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_W-1:0]      in_value,
  input  logic [WID_W-1:0]     in_width,
  input  logic                 in_sext,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_value,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic              s1_valid;
  logic [IN_W-1:0]   s1_value;
  logic [WID_W-1:0]  s1_width;
  logic              s1_sext;

  logic              s2_valid;
  logic [DATA_W-1:0] s2_value;
  logic              s2_err;

  logic              s1_take;
  logic              s2_take;
  logic [DATA_W-1:0] core_result;
  logic              core_err;

  // A stage may load when it is empty or its contents move on this same cycle;
  // in_ready therefore follows out_ready combinationally.
  assign s2_take  = !s2_valid || out_ready;
  assign s1_take  = !s1_valid || s2_take;
  assign in_ready = s1_take;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_value <= '0;
      s1_width <= '0;
      s1_sext  <= 1'b0;
    end else if (s1_take) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_value <= in_value;
        s1_width <= in_width;
        s1_sext  <= in_sext;
      end
    end
  end

  sext_core #(
    .IN_W   (IN_W),
    .DATA_W (DATA_W),
    .WID_W  (WID_W)
  ) u_sext_core (
    .value  (s1_value),
    .width  (s1_width),
    .sext   (s1_sext),
    .result (core_result),
    .err    (core_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_value <= '0;
      s2_err   <= 1'b0;
    end else if (s2_take) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_value <= core_result;
        s2_err   <= core_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (s2_valid && out_ready && s2_err && (err_count != '1)) begin
      err_count <= err_count + ERR_CNT_W'(1);
    end
  end

  assign out_valid = s2_valid;
  assign out_value = s2_value;
  assign out_err   = s2_err;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench for imm_ext_pipe: directed vector table, backpressure and reset
// sequences, plus randomized traffic scored against an arithmetic reference model.
module tb_imm_ext_pipe;

  typedef struct {
    logic [11:0] value;
    logic [3:0]  width;
    logic        sext;
    logic [15:0] exp_value;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [15:0] value;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_value;
  logic [3:0]  in_width;
  logic        in_sext;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_value;
  logic        out_err;
  logic [7:0]  err_count;

  int   n_checks;
  int   n_fail;
  exp_t exp_q[$];
  int   model_err;
  int   out_beats;
  int   run_cur;
  int   run_max;
  logic        hold_pending;
  logic [15:0] held_value;
  logic        held_err;

  imm_ext_pipe #(
    .DATA_W    (16),
    .IN_W      (12),
    .WID_W     (4),
    .ERR_CNT_W (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .in_width  (in_width),
    .in_sext   (in_sext),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value),
    .out_err   (out_err),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: keep the low w bits, then subtract 2^w when the field is negative.
  function automatic exp_t model(input logic [11:0] v, input logic [3:0] w, input logic s);
    exp_t r;
    int   vi;
    int   wi;
    int   low;
    vi = int'(v);
    wi = int'(w);
    if (wi == 0 || wi > 12) begin
      r.value = 16'h0000;
      r.err   = 1'b1;
    end else begin
      low = vi % (1 << wi);
      if (s && (((vi >> (wi - 1)) & 1) == 1)) low = low - (1 << wi) + 65536;
      r.value = low[15:0];
      r.err   = 1'b0;
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic failNow(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s at %0t", name, $time);
  endtask

  // Drive one beat into an otherwise idle pipe and report cycles from accept edge to out_valid.
  task automatic applyStimulus(input logic [11:0] v, input logic [3:0] w, input logic s,
                               output int lat);
    int guard;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_value = v;
    in_width = w;
    in_sext  = s;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard == 20) failNow("accept_timeout");
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Scoreboard: sampled mid-cycle, so it sees exactly what the next rising edge will capture.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pending = 1'b0;
      run_cur      = 0;
    end else begin
      if (hold_pending) begin
        checkOutput("hold_valid", 32'(out_valid), 32'd1);
        checkOutput("hold_value", 32'(out_value), 32'(held_value));
        checkOutput("hold_err", 32'(out_err), 32'(held_err));
      end
      checkOutput("err_count", 32'(err_count), 32'(model_err));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          failNow("spurious_output");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput("sb_value", 32'(out_value), 32'(e.value));
          checkOutput("sb_err", 32'(out_err), 32'(e.err));
          if (e.err && model_err < 255) model_err++;
        end
        out_beats++;
        run_cur++;
        if (run_cur > run_max) run_max = run_cur;
      end else begin
        run_cur = 0;
      end
      hold_pending = out_valid && !out_ready;
      held_value   = out_value;
      held_err     = out_err;
      if (in_valid && in_ready) exp_q.push_back(model(in_value, in_width, in_sext));
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog_timeout");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[10];
    int   lat;
    int   guard;
    int   beats_before;
    exp_t bp_exp[3];

    vecs[0] = '{12'h010, 4'd5,  1'b1, 16'hFFF0, 1'b0};
    vecs[1] = '{12'h1FF, 4'd9,  1'b0, 16'h01FF, 1'b0};
    vecs[2] = '{12'h1FF, 4'd9,  1'b1, 16'hFFFF, 1'b0};
    vecs[3] = '{12'h400, 4'd11, 1'b1, 16'hFC00, 1'b0};
    vecs[4] = '{12'h800, 4'd12, 1'b1, 16'hF800, 1'b0};
    vecs[5] = '{12'hABC, 4'd0,  1'b1, 16'h0000, 1'b1};
    vecs[6] = '{12'hABC, 4'd13, 1'b0, 16'h0000, 1'b1};
    vecs[7] = '{12'h007, 4'd4,  1'b1, 16'h0007, 1'b0};
    vecs[8] = '{12'h001, 4'd1,  1'b1, 16'hFFFF, 1'b0};
    vecs[9] = '{12'hFFF, 4'd11, 1'b0, 16'h07FF, 1'b0};

    n_checks = 0; n_fail = 0; model_err = 0; out_beats = 0;
    run_cur = 0; run_max = 0; hold_pending = 1'b0;
    held_value = '0; held_err = 1'b0;
    rst_n = 1'b0; in_valid = 1'b0; in_value = '0; in_width = '0; in_sext = 1'b0;
    out_ready = 1'b1;

    #12;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_value", 32'(out_value), 32'd0);
    checkOutput("rst_out_err", 32'(out_err), 32'd0);
    checkOutput("rst_err_count", 32'(err_count), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("[TB] directed vector table");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].value, vecs[i].width, vecs[i].sext, lat);
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
      checkOutput($sformatf("vec%0d_value", i), 32'(out_value), 32'(vecs[i].exp_value));
      checkOutput($sformatf("vec%0d_err", i), 32'(out_err), 32'(vecs[i].exp_err));
      @(posedge clk); #1;
    end
    checkOutput("table_err_count", 32'(err_count), 32'd2);

    $display("[TB] backpressure A,B,C");
    bp_exp[0] = model(12'h03C, 4'd6, 1'b1);
    bp_exp[1] = model(12'h00F, 4'd5, 1'b0);
    bp_exp[2] = model(12'h155, 4'd9, 1'b1);
    out_ready = 1'b0;
    in_valid = 1'b1; in_value = 12'h03C; in_width = 4'd6; in_sext = 1'b1;
    @(posedge clk); #1;
    in_value = 12'h00F; in_width = 4'd5; in_sext = 1'b0;
    @(posedge clk); #1;
    in_value = 12'h155; in_width = 4'd9; in_sext = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("bp_in_ready_low", 32'(in_ready), 32'd0);
      checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_in_ready_release", 32'(in_ready), 32'd1);
    checkOutput("bp_order_a", 32'(out_value), 32'(bp_exp[0].value));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("bp_valid_b", 32'(out_valid), 32'd1);
    checkOutput("bp_order_b", 32'(out_value), 32'(bp_exp[1].value));
    @(negedge clk);
    checkOutput("bp_valid_c", 32'(out_valid), 32'd1);
    checkOutput("bp_order_c", 32'(out_value), 32'(bp_exp[2].value));
    @(negedge clk);
    checkOutput("bp_drained", 32'(out_valid), 32'd0);

    $display("[TB] 20 back-to-back beats");
    @(posedge clk); #1;
    run_max = 0;
    beats_before = out_beats;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_value = 12'($urandom);
      in_width = 4'($urandom_range(1, 12));
      in_sext  = 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("b2b_run_length", 32'(run_max), 32'd20);
    checkOutput("b2b_beats", 32'(out_beats - beats_before), 32'd20);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom);
      in_value  = 12'($urandom);
      in_width  = 4'($urandom_range(0, 15));
      in_sext   = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("random_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] err_count saturation");
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'b1;
      in_value = 12'($urandom);
      in_width = (i % 2 == 0) ? 4'd0 : 4'($urandom_range(13, 15));
      in_sext  = 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("err_saturated", 32'(err_count), 32'hFF);

    $display("[TB] reset with beats in flight");
    out_ready = 1'b0;
    in_valid = 1'b1; in_value = 12'h123; in_width = 4'd7; in_sext = 1'b1;
    @(posedge clk); #1;
    in_value = 12'h456; in_width = 4'd8;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("pre_reset_valid", 32'(out_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_valid", 32'(out_valid), 32'd0);
    checkOutput("async_reset_err_count", 32'(err_count), 32'd0);
    exp_q.delete();
    model_err = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("post_reset_idle", 32'(out_valid), 32'd0);
    end
    applyStimulus(12'h010, 4'd5, 1'b1, lat);
    checkOutput("post_reset_latency", 32'(lat), 32'd2);
    checkOutput("post_reset_value", 32'(out_value), 32'hFFF0);
    repeat (3) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
